if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage between the PC register and decode.
- Takes the current `pc`, issues one request at a time to instruction memory, and captures the returned word into a single-entry IF/ID buffer with a valid/ready handshake to decode.
- Drives the PC register's enable (`pc_en`) so the PC advances only when a fetch completes or a redirect (flush) occurs.

Parameters:
- NOP_INST, 32'h0000_0013, word placed in `id_inst` when the buffer holds no real instruction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc  in  32  current PC-register value
- pc_en  out  1  enable to the PC register; PC loads npc on the next edge
- flush  in  1  redirect from execute; npc selects the target this cycle
- imem_req  out  1  instruction-memory request strobe; one cycle per request
- imem_addr  out  32  request address
- imem_rvalid  in  1  response valid; single-cycle pulse, ≥1 cycle after the request
- imem_rdata  in  32  response instruction word
- id_valid  out  1  IF/ID buffer holds an instruction
- id_ready  in  1  decode accepts the buffer this cycle
- id_pc  out  32  PC of the buffered instruction
- id_inst  out  32  buffered instruction
- id_misalign  out  1  buffered entry is a misaligned-fetch exception

Behaviour:
- Reset values: state=REQ, id_valid=0, id_pc=0, id_inst=NOP_INST, id_misalign=0. `pc_en`=0 and `imem_req`=0 while rst=1 (combinational gate). Priority: rst > flush > normal.
- Buffer-free condition: free = !id_valid || id_ready. When id_valid && id_ready and nothing is loaded, id_valid clears next edge.
- State REQ:
  - If flush: no request, stay REQ.
  - Else if free and pc[1:0]==0: imem_req=1, imem_addr=pc, latch req_pc=pc, go WAIT.
  - Else if free and pc[1:0]!=0: no request; load buffer {id_pc=pc, id_inst=NOP_INST, id_misalign=1, id_valid=1}; pc_en=0; go HALT.
  - Else: wait.
- State WAIT:
  - If flush && imem_rvalid: discard data, go REQ.
  - Else if flush: go DRAIN.
  - Else if imem_rvalid: load buffer {req_pc, imem_rdata, misalign=0, valid=1}; pc_en=1; go REQ.
  - The buffer is always empty in WAIT: a request is issued only when free, and only this block fills the buffer.
- State DRAIN: on imem_rvalid, discard and go REQ. A further flush is absorbed (pc_en=1), stay DRAIN.
- State HALT: no requests; buffer keeps the misalign entry until accepted. Leave only via flush, go REQ.
- Flush in any state:
  - pc_en=1 that cycle.
  - id_valid=0 next edge, overriding any load that cycle.
  - id_misalign=0 next edge.
- pc_en is otherwise 0, and is combinational from state/inputs.
- Timing: request at cycle t, rvalid at t+k gives id_valid at t+k+1 and the next request at t+k+1 (if free). Peak throughput is 1 instruction per (k+1) cycles; at most one request outstanding.
- Reset mid-WAIT: go REQ. A late rvalid arriving in REQ is ignored.
- imem_addr=pc when idle (don't-care when imem_req=0).

Test Plan:
- Reset, PC=0x00400000, memory k=1 returning 0x00500093; id_ready=1 → imem_req at cycle 1 with addr 0x00400000; pc_en=1 at cycle 2; id_valid=1, id_pc=0x00400000, id_inst=0x00500093 at cycle 3; next request at cycle 3 for addr 0x00400004.
- id_ready=0 after the first fetch → no second imem_req while id_valid=1; raising id_ready issues a request in the same cycle.
- Flush asserted in WAIT (k=3) → pc_en=1 that cycle; state DRAIN; the rvalid 2 cycles later is discarded (id_valid stays 0); next request uses the redirected pc.
- Flush and imem_rvalid in the same cycle → data discarded, id_valid=0, state REQ next cycle, one pc_en pulse.
- pc=0x00400002 in REQ with buffer free → no imem_req; id_valid=1, id_misalign=1, id_inst=0x00000013; stays halted for 10 cycles; flush → REQ.
- rst asserted in WAIT → id_valid=0; a later rvalid is ignored; a fresh request is issued after rst deasserts.

Source files
------------

// File: rtl/if_stage.sv
// +--------------------------------------------------------------------------+
// | if_stage : single-outstanding instruction fetch feeding a 1-entry IF/ID  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_misalign
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_req_pc;
  logic        w_free;
  logic        w_req;
  logic        w_pc_en;
  logic        w_ld_fetch;
  logic        w_ld_mis;

  assign w_free = !id_valid || id_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_pc_en     = 1'b0;
    w_ld_fetch  = 1'b0;
    w_ld_mis    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (flush) begin
          w_pc_en = 1'b1;
        end else if (w_free && pc[1:0] == 2'b00) begin
          w_req       = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (w_free) begin
          w_ld_mis    = 1'b1;
          w_state_nxt = S_HALT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_pc_en     = 1'b1;
          w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          w_ld_fetch  = 1'b1;
          w_pc_en     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale response still has to be consumed even if another redirect lands.
        w_pc_en = flush;
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HALT: begin
        if (flush) begin
          w_pc_en     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign imem_req  = w_req & ~rst;
  assign pc_en     = w_pc_en & ~rst;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_req_pc    <= 32'd0;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_inst     <= NOP_INST;
      id_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req) begin
        r_req_pc <= pc;
      end
      // Redirect wins over any buffer load in the same cycle.
      if (flush) begin
        id_valid    <= 1'b0;
        id_inst     <= NOP_INST;
        id_misalign <= 1'b0;
      end else if (w_ld_fetch) begin
        id_valid    <= 1'b1;
        id_pc       <= r_req_pc;
        id_inst     <= imem_rdata;
        id_misalign <= 1'b0;
      end else if (w_ld_mis) begin
        id_valid    <= 1'b1;
        id_pc       <= pc;
        id_inst     <= NOP_INST;
        id_misalign <= 1'b1;
      end else if (id_valid && id_ready) begin
        id_valid <= 1'b0;
        id_inst  <= NOP_INST;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// +--------------------------------------------------------------------------+
// | tb_if_stage : directed + random fetch traffic against a transaction model|
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_misalign;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_misalign(id_misalign)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level model: one fetch in flight, possibly marked for discard.
  logic        m_busy, m_drop, m_halt, m_valid, m_mis;
  logic [31:0] m_pc, m_inst, m_req_pc;
  logic        e_free, e_req, e_pc_en;

  int          mem_cnt = -1;
  int          mem_k   = 1;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] target   = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present this cycle's memory response, then compare against the model.
  task automatic drive();
    imem_rvalid = (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    #1;
    e_free  = !m_valid || id_ready;
    e_req   = !rst && !flush && !m_busy && !m_halt && e_free && pc[1:0] == 2'b00;
    e_pc_en = !rst && (flush || (m_busy && !m_drop && imem_rvalid));
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("pc_en", 32'(pc_en), 32'(e_pc_en));
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    if (e_req) chk("imem_addr", imem_addr, pc);
    if (m_valid) begin
      chk("id_pc", id_pc, m_pc);
      chk("id_inst", id_inst, m_inst);
      chk("id_misalign", 32'(id_misalign), 32'(m_mis));
    end
  endtask

  task automatic advance();
    logic got, mis_ld;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_drop = 0; m_halt = 0; m_valid = 0; m_mis = 0;
      m_pc = 32'd0; m_inst = NOP;
    end else begin
      got    = m_busy && imem_rvalid;
      mis_ld = !flush && !m_busy && !m_halt && e_free && pc[1:0] != 2'b00;
      if (m_valid && id_ready) m_valid = 0;
      if (flush) begin
        m_valid = 0; m_mis = 0; m_halt = 0;
        if (m_busy && !got) m_drop = 1;
        else begin m_busy = 0; m_drop = 0; end
      end else if (got) begin
        if (!m_drop) begin
          m_valid = 1; m_pc = m_req_pc; m_inst = imem_rdata; m_mis = 0;
        end
        m_busy = 0; m_drop = 0;
      end else if (e_req) begin
        m_busy = 1; m_req_pc = pc;
      end else if (mis_ld) begin
        m_valid = 1; m_pc = pc; m_inst = NOP; m_mis = 1; m_halt = 1;
      end
    end
    // Memory: responds exactly mem_k cycles after each request it sees.
    if (imem_rvalid) mem_cnt = -1;
    else if (mem_cnt > 0) mem_cnt--;
    if (e_req) begin mem_cnt = mem_k - 1; mem_addr = pc; end
    // PC register.
    if (!rst && e_pc_en) pc = flush ? target : pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic to_req();
    int n;
    n = 0;
    drive();
    while (!e_req && n < 30) begin
      advance();
      drive();
      n++;
    end
    chk("req_timeout", 32'(imem_req), 32'd1);
  endtask

  initial begin
    rst = 1; flush = 0; id_ready = 1; imem_rvalid = 0; imem_rdata = 0;
    pc = 32'h0040_0000;
    m_busy = 0; m_drop = 0; m_halt = 0; m_valid = 0; m_mis = 0;
    m_pc = 0; m_inst = NOP; m_req_pc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_misalign", 32'(id_misalign), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    @(negedge clk);

    // First fetch, k=1.
    rst = 0; mem_k = 1;
    drive();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0040_0000);
    advance(); drive();
    chk("t2_pc_en", 32'(pc_en), 32'd1);
    advance(); drive();
    chk("t3_valid", 32'(id_valid), 32'd1);
    chk("t3_id_pc", id_pc, 32'h0040_0000);
    chk("t3_inst", id_inst, 32'h0050_0093);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h0040_0004);
    advance();

    // Backpressure from decode.
    id_ready = 0;
    drive(); advance();
    for (int i = 0; i < 3; i++) begin
      drive();
      chk("bp_noreq", 32'(imem_req), 32'd0);
      chk("bp_valid", 32'(id_valid), 32'd1);
      advance();
    end
    id_ready = 1;
    drive();
    chk("bp_release_req", 32'(imem_req), 32'd1);
    mem_k = 3;
    advance();

    // Flush while waiting, k=3.
    flush = 1; target = 32'h0040_1000;
    drive();
    chk("wflush_pc_en", 32'(pc_en), 32'd1);
    advance();
    flush = 0;
    drive();
    chk("drain_noreq", 32'(imem_req), 32'd0);
    advance();
    mem_k = 2;
    to_req();
    chk("redir_addr", imem_addr, 32'h0040_1000);
    advance();

    // Flush coinciding with the response.
    drive(); advance();
    flush = 1; target = 32'h0040_2000;
    drive();
    chk("coinc_rvalid", 32'(imem_rvalid), 32'd1);
    chk("coinc_pc_en", 32'(pc_en), 32'd1);
    advance();
    flush = 0;
    drive();
    chk("coinc_valid", 32'(id_valid), 32'd0);
    chk("coinc_pc_en_once", 32'(pc_en), 32'd0);
    chk("coinc_req", 32'(imem_req), 32'd1);
    chk("coinc_addr", imem_addr, 32'h0040_2000);
    advance();

    // Misaligned redirect.
    flush = 1; target = 32'h0040_0002;
    drive(); advance();
    flush = 0; id_ready = 0;
    for (int i = 0; i < 20; i++) begin
      drive();
      if (id_valid && id_misalign) break;
      advance();
    end
    chk("mis_flag", 32'(id_misalign), 32'd1);
    chk("mis_inst", id_inst, NOP);
    chk("mis_pc", id_pc, 32'h0040_0002);
    for (int i = 0; i < 10; i++) begin
      advance(); drive();
      chk("halt_noreq", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(id_valid), 32'd1);
    end
    flush = 1; target = 32'h0040_3000;
    advance(); drive();
    chk("halt_flush_pc_en", 32'(pc_en), 32'd1);
    advance();
    flush = 0; id_ready = 1; mem_k = 4;
    drive();
    chk("halt_exit_req", 32'(imem_req), 32'd1);
    chk("halt_exit_valid", 32'(id_valid), 32'd0);
    advance();

    // Reset while waiting; response lands after reset is released.
    drive(); advance();
    rst = 1;
    drive();
    chk("rstw_req", 32'(imem_req), 32'd0);
    chk("rstw_pc_en", 32'(pc_en), 32'd0);
    advance(); drive(); advance();
    rst = 0;
    drive();
    chk("late_rvalid", 32'(imem_rvalid), 32'd1);
    chk("fresh_req", 32'(imem_req), 32'd1);
    chk("fresh_addr", imem_addr, 32'h0040_3000);
    advance(); drive();
    chk("late_ignored", 32'(id_valid), 32'd0);
    advance();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 11) == 0);
      target   = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) target[1:0] = 2'($urandom_range(1, 3));
      mem_k    = $urandom_range(1, 4);
      drive();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
